// File: rtl/core_pkg.sv
// core_pkg: constants shared across the core pipeline (PC select codes, NOP, default XLEN).
package core_pkg;
    localparam int XLEN_DEFAULT = 64;
    localparam logic [1:0] PCSEL_SEQ    = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_JALR   = 2'b10;
    localparam logic [1:0] PCSEL_TRAP   = 2'b11;
    localparam logic [31:0] INST_NOP = 32'h00000013;
endpackage

// File: rtl/instruction_fetch_stage_ifid_register.sv
// ifid_register: pipeline register for pc/instruction/valid with load, hold and flush-to-bubble.
module ifid_register
    import core_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     inst_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc4_o,
    output logic [31:0]     inst_o
);
    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;

    // A bubble keeps the previous pc so downstream never sees a spurious address change.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        if (flush_i) begin
            valid_d = 1'b0;
            inst_d  = INST_NOP;
        end else if (load_i) begin
            valid_d = valid_i;
            inst_d  = valid_i ? inst_i : INST_NOP;
            pc_d    = valid_i ? pc_i : pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= INST_NOP;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign pc4_o   = pc_q + XLEN'(4);
    assign inst_o  = inst_q;
endmodule

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: PC register, next-PC mux, fetch tracker and one-entry skid feeding the IF/ID register.
module instruction_fetch_stage
    import core_pkg::*;
#(
    parameter int              XLEN         = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      pcSel_i,
    input  logic [XLEN-1:0] pcBranch_i,
    input  logic [XLEN-1:0] pcJalr_i,
    input  logic            pcStall_i,
    input  logic            ifidStall_i,
    output logic            imemEn_o,
    output logic [XLEN-1:0] imemAddr_o,
    input  logic [31:0]     imemData_i,
    output logic [XLEN-1:0] ifidPc_o,
    output logic [XLEN-1:0] ifidPc4_o,
    output logic [31:0]     ifidInst_o,
    output logic            ifidValid_o,
    output logic            misalignedTarget_o
);
    logic            redirect, skid_capture;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            mis_q, mis_d;
    logic [XLEN-1:0] fetch_pc_q;
    logic            fetch_valid_q, fetch_valid_d;
    logic            skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_inst_q, skid_inst_d;

    assign redirect   = pcSel_i != PCSEL_SEQ;
    assign imemEn_o   = !rst && !pcStall_i;
    assign imemAddr_o = pc_q;
    assign misalignedTarget_o = mis_q;

    always_comb begin
        target = pcSel_i == PCSEL_BRANCH ? pcBranch_i :
                 pcSel_i == PCSEL_JALR   ? {pcJalr_i[XLEN-1:1], 1'b0} : TRAP_VECTOR;
        pc_d          = redirect ? {target[XLEN-1:2], 2'b00} : pcStall_i ? pc_q : pc_q + XLEN'(4);
        mis_d         = redirect && target[1];
        // The fetch issued in a redirect cycle is wrong-path and must never reach ID.
        fetch_valid_d = imemEn_o && !redirect;
        skid_capture  = ifidStall_i && fetch_valid_q && !redirect;
        skid_valid_d  = redirect ? 1'b0 : skid_capture ? 1'b1 : ifidStall_i ? skid_valid_q : 1'b0;
        skid_pc_d     = skid_capture ? fetch_pc_q : skid_pc_q;
        skid_inst_d   = skid_capture ? imemData_i : skid_inst_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            mis_q         <= 1'b0;
            fetch_pc_q    <= '0;
            fetch_valid_q <= 1'b0;
            skid_valid_q  <= 1'b0;
            skid_pc_q     <= '0;
            skid_inst_q   <= INST_NOP;
        end else begin
            pc_q          <= pc_d;
            mis_q         <= mis_d;
            fetch_pc_q    <= pc_q;
            fetch_valid_q <= fetch_valid_d;
            skid_valid_q  <= skid_valid_d;
            skid_pc_q     <= skid_pc_d;
            skid_inst_q   <= skid_inst_d;
        end
    end

    ifid_register #(.XLEN(XLEN)) u_ifid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (!ifidStall_i),
        .flush_i (redirect),
        .valid_i (skid_valid_q || fetch_valid_q),
        .pc_i    (skid_valid_q ? skid_pc_q : fetch_pc_q),
        .inst_i  (skid_valid_q ? skid_inst_q : imemData_i),
        .valid_o (ifidValid_o),
        .pc_o    (ifidPc_o),
        .pc4_o   (ifidPc4_o),
        .inst_o  (ifidInst_o)
    );
endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: directed vector table plus randomized run against an in-order fetch queue model.
module tb_instruction_fetch_stage;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pcSel;
    logic [63:0] pcBranch, pcJalr;
    logic        pcStall, ifidStall;
    logic        imemEn;
    logic [63:0] imemAddr;
    logic [31:0] imemData = 32'h0;
    logic [63:0] ifidPc, ifidPc4;
    logic [31:0] ifidInst;
    logic        ifidValid, misalignedTarget;

    int checks = 0;
    int failures = 0;

    instruction_fetch_stage dut (
        .clk(clk), .rst(rst), .pcSel_i(pcSel), .pcBranch_i(pcBranch), .pcJalr_i(pcJalr),
        .pcStall_i(pcStall), .ifidStall_i(ifidStall), .imemEn_o(imemEn), .imemAddr_o(imemAddr),
        .imemData_i(imemData), .ifidPc_o(ifidPc), .ifidPc4_o(ifidPc4), .ifidInst_o(ifidInst),
        .ifidValid_o(ifidValid), .misalignedTarget_o(misalignedTarget)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5BD1E995;
    endfunction

    always @(posedge clk) if (imemEn) imemData <= mem_word(imemAddr);

    always @(posedge clk) if (!rst) assert (!(ifidStall && !pcStall)) else $error("protocol violation: ifidStall without pcStall");

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", n, act, exp);
        end
    endtask

    // Reference model: an ordered queue of fetched-but-not-yet-delivered addresses.
    logic [63:0] m_pc;
    logic [63:0] m_q[$];
    logic        m_v, m_mis, m_init = 1'b0;
    logic [63:0] m_idpc;
    logic        s_en;
    logic [63:0] s_addr;

    task automatic model_update(input logic r, input logic [1:0] s, input logic [63:0] t, input logic p, input logic i);
        logic [63:0] tg;
        if (r) begin
            m_pc = 64'h0; m_q.delete(); m_v = 1'b0; m_idpc = 64'h0; m_mis = 1'b0; m_init = 1'b1;
        end else if (s != 2'b00) begin
            tg = s == 2'b01 ? t : s == 2'b10 ? t & ~64'h1 : 64'h100;
            m_mis = tg[1]; m_q.delete(); m_v = 1'b0; m_pc = tg & ~64'h3;
        end else begin
            m_mis = 1'b0;
            if (!i) begin
                m_v = m_q.size() != 0;
                if (m_v) m_idpc = m_q.pop_front();
            end
            if (!p) begin
                m_q.push_back(m_pc);
                m_pc = m_pc + 64'h4;
            end
        end
    endtask

    task automatic step(input logic r, input logic [1:0] s, input logic [63:0] t, input logic p, input logic i);
        rst = r; pcSel = s; pcBranch = t; pcJalr = t; pcStall = p; ifidStall = i;
        #1;
        s_en = imemEn; s_addr = imemAddr;
        chk("model_imemEn", 64'(s_en), 64'(!r && !p));
        if (!r && m_init) chk("model_imemAddr", s_addr, m_pc);
        @(posedge clk);
        model_update(r, s, t, p, i);
        #1;
        chk("model_ifidValid", 64'(ifidValid), 64'(m_v));
        chk("model_ifidPc", ifidPc, m_idpc);
        chk("model_ifidPc4", ifidPc4, m_idpc + 64'h4);
        chk("model_ifidInst", 64'(ifidInst), 64'(m_v ? mem_word(m_idpc) : NOP));
        chk("model_misaligned", 64'(misalignedTarget), 64'(m_mis));
        @(negedge clk);
    endtask

    typedef struct {
        logic rst; logic [1:0] sel; logic [63:0] tgt; logic ps; logic is;
        logic en; logic [63:0] addr; logic v; logic [63:0] pc; logic mis;
    } vec_t;
    vec_t vecs[37];

    initial begin
        vecs[0]  = '{1'b1, 2'd0, 64'h0,  1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0};
        vecs[1]  = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h0,  1'b0, 64'h0,  1'b0};
        vecs[2]  = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h4,  1'b1, 64'h0,  1'b0};
        vecs[3]  = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h8,  1'b1, 64'h4,  1'b0};
        vecs[4]  = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'hC,  1'b1, 64'h8,  1'b0};
        vecs[5]  = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h10, 1'b1, 64'hC,  1'b0};
        vecs[6]  = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h14, 1'b1, 64'h10, 1'b0};
        vecs[7]  = '{1'b0, 2'd1, 64'h40, 1'b0, 1'b0, 1'b1, 64'h18, 1'b0, 64'h10, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h40, 1'b0, 64'h10, 1'b0};
        vecs[9]  = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h44, 1'b1, 64'h40, 1'b0};
        vecs[10] = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h48, 1'b1, 64'h44, 1'b0};
        vecs[11] = '{1'b0, 2'd2, 64'h81, 1'b0, 1'b0, 1'b1, 64'h4C, 1'b0, 64'h44, 1'b0};
        vecs[12] = '{1'b0, 2'd2, 64'h86, 1'b0, 1'b0, 1'b1, 64'h80, 1'b0, 64'h44, 1'b1};
        vecs[13] = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h84, 1'b0, 64'h44, 1'b0};
        vecs[14] = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h88, 1'b1, 64'h84, 1'b0};
        vecs[15] = '{1'b0, 2'd1, 64'h18, 1'b0, 1'b0, 1'b1, 64'h8C, 1'b0, 64'h84, 1'b0};
        vecs[16] = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h18, 1'b0, 64'h84, 1'b0};
        vecs[17] = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h1C, 1'b1, 64'h18, 1'b0};
        vecs[18] = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h20, 1'b1, 64'h1C, 1'b0};
        vecs[19] = '{1'b0, 2'd0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h24, 1'b1, 64'h1C, 1'b0};
        vecs[20] = '{1'b0, 2'd0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h24, 1'b1, 64'h1C, 1'b0};
        vecs[21] = '{1'b0, 2'd0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h24, 1'b1, 64'h1C, 1'b0};
        vecs[22] = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h24, 1'b1, 64'h20, 1'b0};
        vecs[23] = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h28, 1'b1, 64'h24, 1'b0};
        vecs[24] = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h2C, 1'b1, 64'h28, 1'b0};
        vecs[25] = '{1'b0, 2'd0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h30, 1'b1, 64'h28, 1'b0};
        vecs[26] = '{1'b0, 2'd3, 64'h0,  1'b1, 1'b1, 1'b0, 64'h30, 1'b0, 64'h28, 1'b0};
        vecs[27] = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h100, 1'b0, 64'h28, 1'b0};
        vecs[28] = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h104, 1'b1, 64'h100, 1'b0};
        vecs[29] = '{1'b0, 2'd0, 64'h0,  1'b1, 1'b1, 1'b0, 64'h108, 1'b1, 64'h100, 1'b0};
        vecs[30] = '{1'b1, 2'd0, 64'h0,  1'b0, 1'b0, 1'b0, 64'h0,  1'b0, 64'h0,  1'b0};
        vecs[31] = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h0,  1'b0, 64'h0,  1'b0};
        vecs[32] = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h4,  1'b1, 64'h0,  1'b0};
        vecs[33] = '{1'b0, 2'd1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 1'b0, 1'b1, 64'h8, 1'b0, 64'h0, 1'b0};
        vecs[34] = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 64'h0, 1'b0};
        vecs[35] = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h0,  1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[36] = '{1'b0, 2'd0, 64'h0,  1'b0, 1'b0, 1'b1, 64'h4,  1'b1, 64'h0,  1'b0};

        rst = 1'b1; pcSel = 2'd0; pcBranch = 64'h0; pcJalr = 64'h0; pcStall = 1'b0; ifidStall = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 37; k++) begin
            step(vecs[k].rst, vecs[k].sel, vecs[k].tgt, vecs[k].ps, vecs[k].is);
            chk($sformatf("vec%0d_imemEn", k), 64'(s_en), 64'(vecs[k].en));
            if (!vecs[k].rst) chk($sformatf("vec%0d_imemAddr", k), s_addr, vecs[k].addr);
            chk($sformatf("vec%0d_ifidValid", k), 64'(ifidValid), 64'(vecs[k].v));
            chk($sformatf("vec%0d_ifidPc", k), ifidPc, vecs[k].pc);
            chk($sformatf("vec%0d_ifidPc4", k), ifidPc4, vecs[k].pc + 64'h4);
            chk($sformatf("vec%0d_ifidInst", k), 64'(ifidInst), 64'(vecs[k].v ? mem_word(vecs[k].pc) : NOP));
            chk($sformatf("vec%0d_misaligned", k), 64'(misalignedTarget), 64'(vecs[k].mis));
        end

        for (int n = 0; n < 3000; n++) begin
            logic r, p, i;
            logic [1:0] s;
            logic [63:0] t;
            r = $urandom_range(0, 199) == 0;
            p = $urandom_range(0, 3) == 0;
            i = p && $urandom_range(0, 1) == 1;
            s = $urandom_range(0, 5) == 0 ? 2'($urandom_range(1, 3)) : 2'd0;
            case ($urandom_range(0, 2))
                0: t = {$urandom, $urandom};
                1: t = 64'($urandom_range(0, 4095));
                default: t = 64'hFFFF_FFFF_FFFF_FFE0 | 64'($urandom_range(0, 31));
            endcase
            step(r, s, t, p, i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
